// File: rtl/ibis_texture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibis_texture_pkg : shared types/constants for the texture mapper and fetch  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package ibis_texture_pkg;

    localparam int TILE_SIZE_POW2_DEF = 5;
    localparam int TEXEL_WIDTH_DEF    = 16;
    localparam int TILE_ADDR_WIDTH    = 2 * TILE_SIZE_POW2_DEF;

    typedef logic [TEXEL_WIDTH_DEF-1:0] texel_t;
    typedef logic [TILE_ADDR_WIDTH-1:0] tile_addr_t;

    localparam texel_t BORDER_DEFAULT = '0;

endpackage
`default_nettype wire

// File: rtl/ibis_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibis_sync_fifo : single-clock FIFO with a registered head word             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ibis_sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_POW2 = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic [DEPTH_POW2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << DEPTH_POW2;
    localparam int CNT_W = DEPTH_POW2 + 1;

    logic [WIDTH-1:0]      mem [0:DEPTH-1];
    logic [DEPTH_POW2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_POW2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      head_q, head_d;

    logic                  w_pop;
    logic                  w_push;
    logic [DEPTH_POW2-1:0] w_rd_next;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign head_o    = head_q;
    assign w_pop     = pop_i & ~empty_o;
    assign w_push    = push_i & (~full_o | w_pop);
    assign w_rd_next = rd_ptr_q + DEPTH_POW2'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_POW2'(1);
        end
        if (w_pop) begin
            rd_ptr_d = w_rd_next;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The head register always mirrors mem[rd_ptr]; incoming data bypasses
        // the array when it becomes the new head.
        if (w_push && (empty_o || (w_pop && count_q == CNT_W'(1)))) begin
            head_d = push_data_i;
        end else if (w_pop && count_q > CNT_W'(1)) begin
            head_d = mem[w_rd_next];
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibis_texture_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibis_texture_fetch : tile texel RAM lookup, 2-cycle pipeline, output FIFO  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ibis_texture_fetch
    import ibis_texture_pkg::*;
#(
    parameter int TILE_SIZE_POW2  = TILE_SIZE_POW2_DEF,
    parameter int TEXEL_WIDTH     = TEXEL_WIDTH_DEF,
    parameter int FIFO_DEPTH_POW2 = 2
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable_i,
    input  logic                        req_valid_i,
    input  logic [2*TILE_SIZE_POW2-1:0] req_address_i,
    input  logic                        req_stencil_i,
    input  logic [TEXEL_WIDTH-1:0]      border_color_i,
    input  logic                        load_valid_i,
    input  logic [2*TILE_SIZE_POW2-1:0] load_address_i,
    input  logic [TEXEL_WIDTH-1:0]      load_data_i,
    output logic                        load_ready_o,
    output logic [TEXEL_WIDTH-1:0]      texel_data_o,
    output logic                        texel_valid_o,
    input  logic                        texel_ready_i,
    output logic                        overflow_o
);

    localparam int ADDR_W = 2 * TILE_SIZE_POW2;
    localparam int DEPTH  = 1 << FIFO_DEPTH_POW2;
    localparam int CNT_W  = FIFO_DEPTH_POW2 + 1;
    localparam int OCC_W  = CNT_W + 1;

    logic [TEXEL_WIDTH-1:0] tile_ram [0:(1<<ADDR_W)-1];
    logic [TEXEL_WIDTH-1:0] ram_rdata_q;

    logic                   s0_valid_q, s0_valid_d;
    logic                   s0_stencil_q, s0_stencil_d;
    logic [TEXEL_WIDTH-1:0] s0_border_q, s0_border_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [TEXEL_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                   overflow_q, overflow_d;

    logic                   w_req_fire;
    logic                   w_credit;
    logic                   w_accept;
    logic                   w_ram_rd;
    logic                   w_ram_wr;
    logic [OCC_W-1:0]       w_occupancy;
    logic [CNT_W-1:0]       w_fifo_count;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;

    // Credit counts FIFO entries plus everything still in the pipe, so a push
    // can never land on a full FIFO.
    assign w_occupancy  = OCC_W'(w_fifo_count) + OCC_W'(s0_valid_q) + OCC_W'(s1_valid_q);
    assign w_credit     = ~w_fifo_full & (w_occupancy < OCC_W'(DEPTH));
    assign w_req_fire   = enable_i & req_valid_i;
    assign w_accept     = w_req_fire & w_credit;
    assign w_ram_rd     = w_accept & req_stencil_i;
    assign w_ram_wr     = enable_i & load_valid_i & ~w_req_fire;
    assign load_ready_o = ~w_req_fire;
    assign texel_valid_o = ~w_fifo_empty;
    assign overflow_o   = overflow_q;

    always_ff @(posedge aclk) begin
        if (w_ram_wr) begin
            tile_ram[load_address_i] <= load_data_i;
        end
        if (w_ram_rd) begin
            ram_rdata_q <= tile_ram[req_address_i];
        end
    end

    always_comb begin
        s0_valid_d   = w_accept;
        s0_stencil_d = s0_stencil_q;
        s0_border_d  = s0_border_q;
        s1_valid_d   = s0_valid_q;
        s1_data_d    = s1_data_q;
        overflow_d   = overflow_q | (w_req_fire & ~w_credit);
        if (w_accept) begin
            s0_stencil_d = req_stencil_i;
            s0_border_d  = border_color_i;
        end
        if (s0_valid_q) begin
            s1_data_d = s0_stencil_q ? ram_rdata_q : s0_border_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s0_valid_q   <= 1'b0;
            s0_stencil_q <= 1'b0;
            s0_border_q  <= BORDER_DEFAULT;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            s0_valid_q   <= s0_valid_d;
            s0_stencil_q <= s0_stencil_d;
            s0_border_q  <= s0_border_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            overflow_q   <= overflow_d;
        end
    end

    ibis_sync_fifo #(
        .WIDTH      (TEXEL_WIDTH),
        .DEPTH_POW2 (FIFO_DEPTH_POW2)
    ) u_out_fifo (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .push_i      (s1_valid_q),
        .push_data_i (s1_data_q),
        .pop_i       (texel_ready_i),
        .head_o      (texel_data_o),
        .count_o     (w_fifo_count),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_ibis_texture_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ibis_texture_fetch : directed self-checking bench for ibis_texture_fetch |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ibis_texture_fetch;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable_i;
    logic        req_valid_i;
    logic [9:0]  req_address_i;
    logic        req_stencil_i;
    logic [15:0] border_color_i;
    logic        load_valid_i;
    logic [9:0]  load_address_i;
    logic [15:0] load_data_i;
    logic        load_ready_o;
    logic [15:0] texel_data_o;
    logic        texel_valid_o;
    logic        texel_ready_i;
    logic        overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0]  burst_addr [0:4];
    logic [15:0] burst_data [0:4];

    ibis_texture_fetch dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .enable_i       (enable_i),
        .req_valid_i    (req_valid_i),
        .req_address_i  (req_address_i),
        .req_stencil_i  (req_stencil_i),
        .border_color_i (border_color_i),
        .load_valid_i   (load_valid_i),
        .load_address_i (load_address_i),
        .load_data_i    (load_data_i),
        .load_ready_o   (load_ready_o),
        .texel_data_o   (texel_data_o),
        .texel_valid_o  (texel_valid_o),
        .texel_ready_i  (texel_ready_i),
        .overflow_o     (overflow_o)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic load_word(input logic [9:0] addr, input logic [15:0] data);
        load_valid_i   = 1'b1;
        load_address_i = addr;
        load_data_i    = data;
        tick();
        load_valid_i   = 1'b0;
    endtask

    task automatic single_lookup(input string tag, input logic [9:0] addr, input logic stencil,
                                 input logic [15:0] border, input logic [15:0] exp);
        req_valid_i    = 1'b1;
        req_address_i  = addr;
        req_stencil_i  = stencil;
        border_color_i = border;
        tick();
        req_valid_i    = 1'b0;
        tick();
        check_eq({tag, "_t1_valid"}, 32'(texel_valid_o), 32'd0);
        tick();
        check_eq({tag, "_t2_valid"}, 32'(texel_valid_o), 32'd1);
        check_eq({tag, "_t2_data"}, 32'(texel_data_o), 32'(exp));
        texel_ready_i = 1'b1;
        tick();
        check_eq({tag, "_popped"}, 32'(texel_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        burst_addr[0] = 10'h045; burst_data[0] = 16'h1111;
        burst_addr[1] = 10'h046; burst_data[1] = 16'h2222;
        burst_addr[2] = 10'h047; burst_data[2] = 16'h3333;
        burst_addr[3] = 10'h123; burst_data[3] = 16'hBEEF;
        burst_addr[4] = 10'h048; burst_data[4] = 16'h4444;

        aresetn = 1'b0; enable_i = 1'b0; req_valid_i = 1'b0; req_address_i = '0;
        req_stencil_i = 1'b0; border_color_i = '0; load_valid_i = 1'b0;
        load_address_i = '0; load_data_i = '0; texel_ready_i = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", 32'(texel_valid_o), 32'd0);
        check_eq("rst_data", 32'(texel_data_o), 32'd0);
        check_eq("rst_overflow", 32'(overflow_o), 32'd0);
        check_eq("rst_load_ready", 32'(load_ready_o), 32'd1);
        aresetn = 1'b1;
        enable_i = 1'b1;
        tick();

        // Fill the tile, then a stencil-pass lookup and a border substitution
        for (int i = 0; i < 5; i++) load_word(burst_addr[i], burst_data[i]);
        texel_ready_i = 1'b0;
        single_lookup("ram_read", 10'h123, 1'b1, 16'h0000, 16'hBEEF);
        texel_ready_i = 1'b0;
        single_lookup("border", 10'h123, 1'b0, 16'hF81F, 16'hF81F);
        check_eq("no_overflow_yet", 32'(overflow_o), 32'd0);

        // Back-to-back burst with a stalled sink: four fit, the fifth is dropped
        texel_ready_i = 1'b0;
        req_stencil_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid_i   = 1'b1;
            req_address_i = burst_addr[i];
            tick();
        end
        req_valid_i = 1'b0;
        check_eq("burst_overflow", 32'(overflow_o), 32'd1);
        repeat (2) tick();
        texel_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain%0d_valid", i), 32'(texel_valid_o), 32'd1);
            check_eq($sformatf("drain%0d_data", i), 32'(texel_data_o), 32'(burst_data[i]));
            tick();
        end
        check_eq("drain_empty", 32'(texel_valid_o), 32'd0);
        check_eq("overflow_sticky", 32'(overflow_o), 32'd1);

        // Read/load conflict: read wins, held load lands next cycle, re-read sees it
        req_valid_i = 1'b1; req_address_i = 10'h123; req_stencil_i = 1'b1;
        load_valid_i = 1'b1; load_address_i = 10'h200; load_data_i = 16'h5A5A;
        #1;
        check_eq("conflict_load_ready", 32'(load_ready_o), 32'd0);
        tick();
        req_valid_i = 1'b0;
        #1;
        check_eq("retry_load_ready", 32'(load_ready_o), 32'd1);
        tick();
        load_valid_i = 1'b0;
        req_valid_i = 1'b1; req_address_i = 10'h200;
        tick();
        req_valid_i = 1'b0;
        check_eq("conflict_read_valid", 32'(texel_valid_o), 32'd1);
        check_eq("conflict_read_data", 32'(texel_data_o), 32'hBEEF);
        tick();
        check_eq("reread_gap", 32'(texel_valid_o), 32'd0);
        tick();
        check_eq("reread_valid", 32'(texel_valid_o), 32'd1);
        check_eq("reread_data", 32'(texel_data_o), 32'h5A5A);
        tick();

        // Disabled: request ignored, load does not land
        enable_i = 1'b0;
        req_valid_i = 1'b1; req_address_i = 10'h123;
        load_valid_i = 1'b1; load_address_i = 10'h123; load_data_i = 16'h0BAD;
        #1;
        check_eq("disabled_load_ready", 32'(load_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0; load_valid_i = 1'b0;
        repeat (3) tick();
        check_eq("disabled_no_output", 32'(texel_valid_o), 32'd0);
        enable_i = 1'b1;
        texel_ready_i = 1'b0;
        single_lookup("disabled_load", 10'h123, 1'b1, 16'h0000, 16'hBEEF);

        // Reset mid-operation with lookups both queued and in flight
        texel_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid_i   = 1'b1;
            req_address_i = burst_addr[i];
            tick();
        end
        req_valid_i = 1'b0;
        check_eq("pre_reset_valid", 32'(texel_valid_o), 32'd1);
        aresetn = 1'b0;
        tick();
        check_eq("midrst_valid", 32'(texel_valid_o), 32'd0);
        check_eq("midrst_data", 32'(texel_data_o), 32'd0);
        check_eq("midrst_overflow", 32'(overflow_o), 32'd0);
        aresetn = 1'b1;
        repeat (3) tick();
        check_eq("flushed_pipe", 32'(texel_valid_o), 32'd0);
        single_lookup("ram_retained", 10'h123, 1'b1, 16'h0000, 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
